// File: rtl/pixel_loader_if.sv
// Image ROM bus between the pixel loader and the dual-read-port image ROM.
// Addresses are registered by the loader; data is expected in the cycle the address is held.
interface pixel_loader_if #(
    parameter int ADDR_W = 19
) ();
    logic [ADDR_W-1:0] BG_ADDR;
    logic [7:0]        BG_DATA;
    logic [ADDR_W-1:0] SP_ADDR;
    logic [7:0]        SP_DATA;

    modport master (
        output BG_ADDR,
        output SP_ADDR,
        input  BG_DATA,
        input  SP_DATA
    );

    modport slave (
        input  BG_ADDR,
        input  SP_ADDR,
        output BG_DATA,
        output SP_DATA
    );
endinterface

// File: rtl/pixel_loader.sv
// Pixel source for the VGA controller: layer select, ROM fetch, transparency
// and palette lookup in a fixed 3-stage pipeline.
module pixel_loader #(
    parameter int ADDR_W = 19,
    parameter int BG_W = 360,
    parameter int BG_H = 360,
    parameter int BG_BASE = 0,
    parameter int BLUE_X = 192,
    parameter int BLUE_Y = 193,
    parameter int BLUE_W = 168,
    parameter int BLUE_H = 167,
    parameter int GREEN_X = 0,
    parameter int GREEN_Y = 0,
    parameter int GREEN_W = 168,
    parameter int GREEN_H = 168,
    parameter int RED_X = 191,
    parameter int RED_Y = 0,
    parameter int RED_W = 169,
    parameter int RED_H = 168,
    parameter int YELLOW_X = 0,
    parameter int YELLOW_Y = 192,
    parameter int YELLOW_W = 168,
    parameter int YELLOW_H = 167,
    parameter int LOSE_X = 0,
    parameter int LOSE_Y = 113,
    parameter int LOSE_W = 360,
    parameter int LOSE_H = 134,
    parameter int WIN_X = 0,
    parameter int WIN_Y = 122,
    parameter int WIN_W = 360,
    parameter int WIN_H = 116,
    parameter int PWR_X = 169,
    parameter int PWR_Y = 197,
    parameter int PWR_W = 22,
    parameter int PWR_H = 21,
    parameter int BLUE_BASE = BG_BASE + BG_W * BG_H,
    parameter int GREEN_BASE = BLUE_BASE + BLUE_W * BLUE_H,
    parameter int RED_BASE = GREEN_BASE + GREEN_W * GREEN_H,
    parameter int YELLOW_BASE = RED_BASE + RED_W * RED_H,
    parameter int LOSE_BASE = YELLOW_BASE + YELLOW_W * YELLOW_H,
    parameter int WIN_BASE = LOSE_BASE + LOSE_W * LOSE_H,
    parameter int PWR_BASE = WIN_BASE + WIN_W * WIN_H,
    parameter logic [7:0] TRANSP_IDX = 8'd0
) (
    input  logic           VGA_CLK,
    input  logic           RESET_N,
    input  logic [10:0]    X,
    input  logic [10:0]    Y,
    input  logic [7:0]     SPRITES_EN,
    pixel_loader_if.master rom,
    input  logic           PAL_WE,
    input  logic [7:0]     PAL_WADDR,
    input  logic [23:0]    PAL_WDATA,
    output logic [23:0]    RGB,
    output logic           PIX_VALID
);

    // Enables are asserted inclusively at the far edge, so clamp into the sprite.
    function automatic logic [ADDR_W-1:0] loc(
        input logic [10:0] x,
        input logic [10:0] y,
        input int          sx,
        input int          sy,
        input int          w,
        input int          h,
        input int          base
    );
        logic [10:0] lx;
        logic [10:0] ly;
        lx = x - 11'(sx);
        ly = y - 11'(sy);
        if (lx > 11'(w - 1)) lx = 11'(w - 1);
        if (ly > 11'(h - 1)) ly = 11'(h - 1);
        return ADDR_W'(base) + ADDR_W'(ly) * ADDR_W'(w) + ADDR_W'(lx);
    endfunction

    logic              in_win;
    logic              hit;
    logic [ADDR_W-1:0] bg_nxt;
    logic [ADDR_W-1:0] sp_nxt;

    logic              hit1;
    logic              v1;
    logic [7:0]        idx;
    logic              v2;
    logic [23:0]       pal [256];

    assign in_win = SPRITES_EN[7] && (X != 11'h7FF) && (Y != 11'h7FF);

    always_comb begin
        bg_nxt = ADDR_W'(BG_BASE) + ADDR_W'(Y) * ADDR_W'(BG_W) + ADDR_W'(X);
    end

    always_comb begin
        hit    = 1'b1;
        sp_nxt = '0;
        priority case (1'b1)
            SPRITES_EN[1]: sp_nxt = loc(X, Y, WIN_X, WIN_Y, WIN_W, WIN_H, WIN_BASE);
            SPRITES_EN[2]: sp_nxt = loc(X, Y, LOSE_X, LOSE_Y, LOSE_W, LOSE_H, LOSE_BASE);
            SPRITES_EN[0]: sp_nxt = loc(X, Y, PWR_X, PWR_Y, PWR_W, PWR_H, PWR_BASE);
            SPRITES_EN[6]: sp_nxt = loc(X, Y, BLUE_X, BLUE_Y, BLUE_W, BLUE_H, BLUE_BASE);
            SPRITES_EN[5]: sp_nxt = loc(X, Y, GREEN_X, GREEN_Y, GREEN_W, GREEN_H, GREEN_BASE);
            SPRITES_EN[4]: sp_nxt = loc(X, Y, RED_X, RED_Y, RED_W, RED_H, RED_BASE);
            SPRITES_EN[3]: sp_nxt = loc(X, Y, YELLOW_X, YELLOW_Y, YELLOW_W, YELLOW_H, YELLOW_BASE);
            default:       hit = 1'b0;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            rom.BG_ADDR <= '0;
            rom.SP_ADDR <= '0;
            hit1        <= 1'b0;
            v1          <= 1'b0;
        end else begin
            rom.BG_ADDR <= in_win ? bg_nxt : '0;
            rom.SP_ADDR <= (in_win && hit) ? sp_nxt : '0;
            hit1        <= in_win && hit;
            v1          <= in_win;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            idx <= '0;
            v2  <= 1'b0;
        end else begin
            idx <= (hit1 && rom.SP_DATA != TRANSP_IDX) ? rom.SP_DATA : rom.BG_DATA;
            v2  <= v1;
        end
    end

    // Palette survives reset; reads see the value from before a same-edge write.
    always_ff @(posedge VGA_CLK) begin
        if (PAL_WE) pal[PAL_WADDR] <= PAL_WDATA;
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            RGB       <= '0;
            PIX_VALID <= 1'b0;
        end else begin
            RGB       <= v2 ? pal[idx] : 24'h000000;
            PIX_VALID <= v2;
        end
    end

endmodule
